// File: rtl/ptp_tsq_regs.sv
`timescale 1ns/1ps
// ptp_tsq_regs: per-channel register windows, pop sequencer and shadow capture for PTP TSU queues.
// Build option: define PTP_TSQ_IRQ_EN to generate the IRQEN registers and the registered irq_out.
module ptp_tsq_regs #(
   parameter int NUM_CH  = 2,
   parameter int DATA_W  = 128,
   parameter int TS_W    = 80,
   parameter int POP_LAT = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_in,
   input  logic                     rd_in,
   input  logic [7:0]               addr_in,
   input  logic [31:0]              data_in,
   output logic [31:0]              data_out,
   output logic                     rd_valid_out,
   output logic [NUM_CH-1:0]        q_rd_en_out,
   output logic [NUM_CH-1:0]        q_rst_out,
   output logic [8*NUM_CH-1:0]      q_mask_out,
   input  logic [NUM_CH-1:0]        q_empty_in,
   input  logic [8*NUM_CH-1:0]      q_level_in,
   input  logic [NUM_CH-1:0]        q_ovf_in,
   input  logic [DATA_W*NUM_CH-1:0] q_data_in,
   input  logic [TS_W*NUM_CH-1:0]   q_ts_in,
   output logic                     irq_out
);

   localparam int DW = DATA_W / 32;
   localparam int TW = (TS_W + 31) / 32;

   typedef enum logic [1:0] {S_IDLE, S_POP, S_WAIT} state_t;

   logic [1:0]              ch_sel;
   logic [3:0]              word;
   logic [NUM_CH-1:0][31:0] ch_rdata;
   logic [31:0]             rd_mux;
   logic                    unused_bits;

   assign ch_sel      = addr_in[7:6];
   assign word        = addr_in[5:2];
   assign unused_bits = ^{addr_in[1:0], data_in};

`ifdef PTP_TSQ_IRQ_EN
   logic [NUM_CH-1:0] irq_src;
`endif

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic              sel;
      logic              wr_ctrl, wr_stat, wr_mask;
      logic              pop_req, qrst_req, start_pop, udf_set;
      state_t            state_q, state_nxt;
      logic [2:0]        cnt_q, cnt_nxt;
      logic              capture;
      logic              busy, valid_q, ovf_q, udf_q, qrst_q;
      logic [7:0]        mask_q;
      logic [DATA_W-1:0] data_q;
      logic [TS_W-1:0]   ts_q;
      logic [TW*32-1:0]  ts_ext;
      logic [31:0]       irqen_rd;
      logic [31:0]       rdata;

      assign sel       = (ch_sel == 2'(c));
      assign wr_ctrl   = wr_in & sel & (word == 4'h0);
      assign wr_stat   = wr_in & sel & (word == 4'h1);
      assign wr_mask   = wr_in & sel & (word == 4'h2);
      assign pop_req   = wr_ctrl & data_in[0];
      assign qrst_req  = wr_ctrl & data_in[1];
      // A pop request is honoured only from IDLE; QRST in the same write suppresses it.
      assign start_pop = pop_req & ~qrst_req & (state_q == S_IDLE) & ~q_empty_in[c];
      assign udf_set   = pop_req & ~qrst_req & (state_q == S_IDLE) & q_empty_in[c];
      assign busy      = (state_q != S_IDLE);

      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      always_comb begin
         state_nxt = state_q;
         cnt_nxt   = cnt_q;
         capture   = 1'b0;
         case (state_q)
            S_IDLE: if (start_pop) state_nxt = S_POP;
            S_POP: begin
               cnt_nxt   = 3'(POP_LAT);
               state_nxt = S_WAIT;
            end
            S_WAIT: begin
               cnt_nxt = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  capture   = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
         if (qrst_req) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            capture   = 1'b0;
         end
      end

      // NOTE: all state elements use non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            qrst_q  <= 1'b0;
            mask_q  <= 8'hFF;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
         end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            qrst_q  <= qrst_req;
            if (qrst_req || start_pop) valid_q <= 1'b0;
            else if (capture)          valid_q <= 1'b1;
            if (wr_mask) mask_q <= data_in[7:0];
            ovf_q <= q_ovf_in[c] | (ovf_q & ~(wr_stat & data_in[16]));
            udf_q <= udf_set     | (udf_q & ~(wr_stat & data_in[17]));
         end
      end

      // Shadows are wide; they take a load enable and clear only on reset or QRST.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_q <= '0;
            ts_q   <= '0;
         end else if (qrst_req) begin
            data_q <= '0;
            ts_q   <= '0;
         end else if (capture) begin
            data_q <= q_data_in[c*DATA_W +: DATA_W];
            ts_q   <= q_ts_in[c*TS_W +: TS_W];
         end
      end

`ifdef PTP_TSQ_IRQ_EN
      logic       wr_irqen;
      logic [2:0] irqen_q;

      assign wr_irqen = wr_in & sel & (word == 4'h3);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)        irqen_q <= '0;
         else if (wr_irqen) irqen_q <= data_in[2:0];
      end

      assign irqen_rd   = {29'b0, irqen_q};
      assign irq_src[c] = (valid_q & irqen_q[0]) | (ovf_q & irqen_q[1]) | (~q_empty_in[c] & irqen_q[2]);
`else
      assign irqen_rd = '0;
`endif

      always_comb begin
         ts_ext           = '0;
         ts_ext[TS_W-1:0] = ts_q;
      end

      // Shadow words are presented most-significant word first.
      always_comb begin
         rdata = '0;
         case (word)
            4'h1:    rdata = {14'b0, udf_q, ovf_q, 6'b0, busy, valid_q, q_level_in[8*c +: 8]};
            4'h2:    rdata = {24'b0, mask_q};
            4'h3:    rdata = irqen_rd;
            default: begin
               for (int k = 0; k < DW; k++)
                  if (word == 4'(4 + k)) rdata = data_q[DATA_W-1-32*k -: 32];
               for (int k = 0; k < TW; k++)
                  if (word == 4'(8 + k)) rdata = ts_ext[TW*32-1-32*k -: 32];
            end
         endcase
      end

      assign ch_rdata[c]         = rdata;
      assign q_rd_en_out[c]      = (state_q == S_POP);
      assign q_rst_out[c]        = qrst_q;
      assign q_mask_out[8*c +: 8] = mask_q;
   end

   always_comb begin
      rd_mux = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (ch_sel == 2'(c)) rd_mux = ch_rdata[c];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out     <= '0;
         rd_valid_out <= 1'b0;
      end else begin
         rd_valid_out <= rd_in;
         if (rd_in) data_out <= rd_mux;
      end
   end

`ifdef PTP_TSQ_IRQ_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq_out <= 1'b0;
      else        irq_out <= |irq_src;
   end
`else
   assign irq_out = 1'b0;
`endif

endmodule

// File: tb/tb_ptp_tsq_regs.sv
`timescale 1ns/1ps
// tb_ptp_tsq_regs: scoreboard bench for ptp_tsq_regs with a latency-accurate queue head model.
module tb_ptp_tsq_regs;
   localparam int NCH = 2;
   localparam int DW  = 128;
   localparam int TSW = 80;
   localparam int LAT = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wr_in = 1'b0;
   logic              rd_in = 1'b0;
   logic [7:0]        addr_in = '0;
   logic [31:0]       data_in = '0;
   logic [31:0]       data_out;
   logic              rd_valid_out;
   logic [NCH-1:0]    q_rd_en_out;
   logic [NCH-1:0]    q_rst_out;
   logic [8*NCH-1:0]  q_mask_out;
   logic [NCH-1:0]    q_empty_in = '1;
   logic [8*NCH-1:0]  q_level_in = '0;
   logic [NCH-1:0]    q_ovf_in = '0;
   logic [DW*NCH-1:0] q_data_in;
   logic [TSW*NCH-1:0] q_ts_in;
   logic              irq_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_data[$];
   string       exp_name[$];
   logic        rd_prev = 1'b0;

   logic [7:0]     hist [NCH];
   int             pop_cnt [NCH];
   logic [DW-1:0]  head_data [NCH];
   logic [TSW-1:0] head_ts [NCH];

   ptp_tsq_regs #(.NUM_CH(NCH), .DATA_W(DW), .TS_W(TSW), .POP_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .wr_in(wr_in), .rd_in(rd_in), .addr_in(addr_in),
      .data_in(data_in), .data_out(data_out), .rd_valid_out(rd_valid_out),
      .q_rd_en_out(q_rd_en_out), .q_rst_out(q_rst_out), .q_mask_out(q_mask_out),
      .q_empty_in(q_empty_in), .q_level_in(q_level_in), .q_ovf_in(q_ovf_in),
      .q_data_in(q_data_in), .q_ts_in(q_ts_in), .irq_out(irq_out)
   );

   always #5 clk = ~clk;

   initial begin
      for (int c = 0; c < NCH; c++) begin
         hist[c] = '0; pop_cnt[c] = 0; head_data[c] = '0; head_ts[c] = '0;
      end
   end

   // Queue model: the head is valid only in the cycle LAT cycles after the pop; garbage otherwise.
   always @(negedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         hist[c] = {hist[c][6:0], q_rd_en_out[c]};
         if (q_rd_en_out[c] === 1'b1) pop_cnt[c]++;
         if (hist[c][LAT]) begin
            q_data_in[c*DW +: DW] = head_data[c];
            q_ts_in[c*TSW +: TSW] = head_ts[c];
         end else begin
            q_data_in[c*DW +: DW] = ~head_data[c];
            q_ts_in[c*TSW +: TSW] = ~head_ts[c];
         end
      end
   end

   // Read scoreboard: rd_valid_out must follow rd_in by one cycle and carry the queued value.
   always @(negedge clk) begin
      if (rd_prev || rd_valid_out === 1'b1) begin
         n_checks++;
         if (rd_valid_out !== rd_prev) begin
            n_fail++;
            $display("FAIL rd_valid_timing: got %b expected %b at %0t", rd_valid_out, rd_prev, $time);
         end
      end
      if (rd_valid_out === 1'b1) begin
         n_checks++;
         if (exp_data.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_read: got data %h with no read pending", data_out);
         end else begin
            automatic logic [31:0] e  = exp_data.pop_front();
            automatic string       nm = exp_name.pop_front();
            if (data_out !== e) begin
               n_fail++;
               $display("FAIL %s: got %h expected %h", nm, data_out, e);
            end
         end
      end
      rd_prev = rd_in;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
      wr_in = 1'b1; addr_in = a; data_in = d;
      tick();
      wr_in = 1'b0; data_in = '0;
   endtask

   task automatic reg_rd(input logic [7:0] a, input logic [31:0] e, input string nm);
      rd_in = 1'b1; addr_in = a;
      exp_data.push_back(e); exp_name.push_back(nm);
      tick();
      rd_in = 1'b0;
   endtask

   task automatic drain();
      int b = 0;
      while (exp_data.size() != 0 && b < 20) begin
         tick();
         b++;
      end
      n_checks++;
      if (exp_data.size() != 0) begin
         n_fail++;
         $display("FAIL read_drain: got %0d reads outstanding expected 0", exp_data.size());
         exp_data.delete(); exp_name.delete();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(2);
      n_checks++;
      if ({data_out, rd_valid_out, q_rd_en_out, q_rst_out, irq_out} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h/%b/%b/%b/%b expected all zero",
                  data_out, rd_valid_out, q_rd_en_out, q_rst_out, irq_out);
      end
      n_checks++;
      if (q_mask_out !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL reset_mask: got %h expected ffff", q_mask_out);
      end
      rst_n = 1'b1;
      tick();
      reg_rd(8'h04, 32'h0, "ch0_stat_reset");
      reg_rd(8'h08, 32'hFF, "ch0_mask_reset");
      reg_rd(8'h44, 32'h0, "ch1_stat_reset");
      reg_rd(8'h48, 32'hFF, "ch1_mask_reset");
      reg_rd(8'h10, 32'h0, "ch0_data_reset");
      reg_rd(8'h00, 32'h0, "ch0_ctrl_reads0");
      drain();
   endtask

   task automatic test_mask();
      reg_wr(8'h08, 32'h5A);
      reg_wr(8'h48, 32'h3C);
      n_checks++;
      if (q_mask_out !== 16'h3C5A) begin
         n_fail++;
         $display("FAIL mask_out: got %h expected 3c5a", q_mask_out);
      end
      reg_wr(8'h44, 32'h0000_03FF);
      reg_rd(8'h08, 32'h5A, "ch0_mask_rb");
      reg_rd(8'h48, 32'h3C, "ch1_mask_rb");
      reg_rd(8'h44, 32'h0, "ch1_stat_ro_bits");
      reg_rd(8'h88, 32'h0, "ch2_unmapped");
      reg_rd(8'hC8, 32'h0, "ch3_unmapped");
      drain();
   endtask

   task automatic test_pop();
      int p0 = pop_cnt[0];
      int p1 = pop_cnt[1];
      head_data[1] = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
      head_ts[1]   = 80'h1234_5678_9ABC_DEF0_1234;
      q_empty_in[1] = 1'b0;
      q_level_in[15:8] = 8'd3;
      reg_wr(8'h40, 32'h1);
      reg_rd(8'h44, 32'h0000_0203, "pop_stat_c0");
      reg_rd(8'h44, 32'h0000_0203, "pop_stat_c1");
      reg_rd(8'h44, 32'h0000_0203, "pop_stat_c2");
      reg_rd(8'h44, 32'h0000_0103, "pop_stat_done");
      reg_rd(8'h50, 32'h0123_4567, "pop_data_w0");
      reg_rd(8'h54, 32'h89AB_CDEF, "pop_data_w1");
      reg_rd(8'h58, 32'h0123_4567, "pop_data_w2");
      reg_rd(8'h5C, 32'h89AB_CDEF, "pop_data_w3");
      reg_rd(8'h60, 32'h0000_1234, "pop_ts_w0");
      reg_rd(8'h64, 32'h5678_9ABC, "pop_ts_w1");
      reg_rd(8'h68, 32'hDEF0_1234, "pop_ts_w2");
      reg_rd(8'h6C, 32'h0, "pop_unmapped_6c");
      reg_rd(8'h04, 32'h0, "pop_ch0_untouched");
      drain();
      n_checks++;
      if (pop_cnt[1] != p1 + 1 || pop_cnt[0] != p0) begin
         n_fail++;
         $display("FAIL pop_pulses: got ch1=%0d ch0=%0d expected ch1=%0d ch0=%0d",
                  pop_cnt[1] - p1, pop_cnt[0] - p0, 1, 0);
      end
   endtask

   task automatic test_underflow();
      int p0 = pop_cnt[0];
      reg_wr(8'h00, 32'h1);
      tick(4);
      n_checks++;
      if (pop_cnt[0] != p0) begin
         n_fail++;
         $display("FAIL udf_no_pop: got %0d pops expected 0", pop_cnt[0] - p0);
      end
      reg_rd(8'h04, 32'h0002_0000, "udf_set");
      reg_rd(8'h44, 32'h0000_0103, "udf_ch1_untouched");
      reg_wr(8'h04, 32'h0002_0000);
      reg_rd(8'h04, 32'h0, "udf_w1c");
      drain();
   endtask

   task automatic test_qrst();
      int p1 = pop_cnt[1];
      reg_wr(8'h40, 32'h3);
      n_checks++;
      if (q_rst_out !== 2'b10) begin
         n_fail++;
         $display("FAIL qrst_pulse: got %b expected 10", q_rst_out);
      end
      tick();
      n_checks++;
      if (q_rst_out !== 2'b00) begin
         n_fail++;
         $display("FAIL qrst_single: got %b expected 00", q_rst_out);
      end
      tick(3);
      n_checks++;
      if (pop_cnt[1] != p1) begin
         n_fail++;
         $display("FAIL qrst_wins: got %0d pops expected 0", pop_cnt[1] - p1);
      end
      reg_rd(8'h44, 32'h0000_0003, "qrst_stat");
      reg_rd(8'h50, 32'h0, "qrst_data_clr");
      reg_rd(8'h68, 32'h0, "qrst_ts_clr");
      drain();
   endtask

   task automatic test_back_to_back();
      int p1 = pop_cnt[1];
      head_data[1] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      head_ts[1]   = 80'hAAAA_BBBB_CCCC_DDDD_EEEE;
      reg_wr(8'h40, 32'h1);
      tick();
      reg_wr(8'h40, 32'h1);
      tick(4);
      n_checks++;
      if (pop_cnt[1] != p1 + 1) begin
         n_fail++;
         $display("FAIL busy_pop_ignored: got %0d pops expected 1", pop_cnt[1] - p1);
      end
      reg_rd(8'h44, 32'h0000_0103, "busy_stat");
      reg_rd(8'h5C, 32'h7777_8888, "busy_data_w3");
      reg_rd(8'h60, 32'h0000_AAAA, "busy_ts_w0");
      drain();
   endtask

   task automatic test_ovf();
      q_ovf_in = 2'b01;
      tick();
      q_ovf_in = 2'b00;
      reg_rd(8'h04, 32'h0001_0000, "ovf_set");
      wr_in = 1'b1; addr_in = 8'h04; data_in = 32'h0001_0000; q_ovf_in = 2'b01;
      tick();
      wr_in = 1'b0; data_in = '0; q_ovf_in = 2'b00;
      reg_rd(8'h04, 32'h0001_0000, "ovf_set_wins");
      reg_rd(8'h44, 32'h0000_0103, "ovf_ch1_untouched");
      reg_wr(8'h04, 32'h0001_0000);
      reg_rd(8'h04, 32'h0, "ovf_w1c");
      drain();
   endtask

`ifdef PTP_TSQ_IRQ_EN
   task automatic test_irq();
      reg_wr(8'h40, 32'h2);
      reg_wr(8'h4C, 32'h1);
      tick(2);
      n_checks++;
      if (irq_out !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_idle: got %b expected 0", irq_out);
      end
      reg_wr(8'h40, 32'h1);
      tick(3);
      n_checks++;
      if (irq_out !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_early: got %b expected 0", irq_out);
      end
      tick();
      n_checks++;
      if (irq_out !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_valid: got %b expected 1", irq_out);
      end
      reg_rd(8'h4C, 32'h1, "irqen_rb");
      reg_wr(8'h40, 32'h2);
      tick();
      n_checks++;
      if (irq_out !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_qrst_clear: got %b expected 0", irq_out);
      end
      reg_wr(8'h0C, 32'h2);
      q_ovf_in = 2'b01;
      tick();
      q_ovf_in = 2'b00;
      tick();
      n_checks++;
      if (irq_out !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_ovf: got %b expected 1", irq_out);
      end
      reg_wr(8'h04, 32'h0001_0000);
      tick();
      n_checks++;
      if (irq_out !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_ovf_w1c: got %b expected 0", irq_out);
      end
      reg_wr(8'h4C, 32'h4);
      tick();
      n_checks++;
      if (irq_out !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_nonempty: got %b expected 1", irq_out);
      end
      reg_wr(8'h4C, 32'h0);
      reg_wr(8'h0C, 32'h0);
      tick();
      n_checks++;
      if (irq_out !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_disabled: got %b expected 0", irq_out);
      end
      drain();
   endtask
`else
   task automatic test_irq();
      reg_wr(8'h4C, 32'h7);
      reg_wr(8'h0C, 32'h7);
      reg_rd(8'h4C, 32'h0, "irqen_absent");
      q_ovf_in = 2'b01;
      tick();
      q_ovf_in = 2'b00;
      tick(2);
      n_checks++;
      if (irq_out !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_tied_low: got %b expected 0", irq_out);
      end
      reg_wr(8'h04, 32'h0001_0000);
      drain();
   endtask
`endif

   task automatic test_async_reset();
      int p1 = pop_cnt[1];
      head_data[1] = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
      reg_wr(8'h40, 32'h1);
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({data_out, rd_valid_out, q_rd_en_out, q_rst_out, irq_out} !== '0 || q_mask_out !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL async_reset: got %h/%b/%b/%b/%b mask %h expected zeros mask ffff",
                  data_out, rd_valid_out, q_rd_en_out, q_rst_out, irq_out, q_mask_out);
      end
      tick();
      rst_n = 1'b1;
      tick(4);
      n_checks++;
      if (pop_cnt[1] != p1 + 1) begin
         n_fail++;
         $display("FAIL async_reset_pops: got %0d expected 1", pop_cnt[1] - p1);
      end
      reg_rd(8'h44, 32'h0000_0003, "async_stat");
      reg_rd(8'h50, 32'h0, "async_data");
      reg_rd(8'h08, 32'hFF, "async_mask");
      drain();
   endtask

   initial begin
      test_reset();
      test_mask();
      test_pop();
      test_underflow();
      test_qrst();
      test_back_to_back();
      test_ovf();
      test_irq();
      test_async_reset();
      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
